// File: rtl/scaler_frame_ctrl.sv
// Per-frame sequencer for scaler_core: validates a frame config, derives mode and H/V scale factors
// with one shared restoring divider, starts the core and reports status. Optional: SCALER_FRAME_CTRL_PIXCNT_CHECK_EN.
module scaler_frame_ctrl #(
    parameter int IMG_H_MAX        = 3840,
    parameter int IMG_V_MAX        = 2160,
    parameter int IMG_H_BITWIDTH   = $clog2(IMG_H_MAX),
    parameter int IMG_V_BITWIDTH   = $clog2(IMG_V_MAX),
    parameter int SF_BITWIDTH      = 24,
    parameter int SF_FRAC_BITWIDTH = 20,
    parameter int DIV_W            = ((IMG_H_BITWIDTH > IMG_V_BITWIDTH) ? IMG_H_BITWIDTH : IMG_V_BITWIDTH)
                                     + SF_FRAC_BITWIDTH
) (
    input  logic                      core_clk,
    input  logic                      core_rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [IMG_H_BITWIDTH-1:0] cfg_src_h,
    input  logic [IMG_V_BITWIDTH-1:0] cfg_src_v,
    input  logic [IMG_H_BITWIDTH-1:0] cfg_des_h,
    input  logic [IMG_V_BITWIDTH-1:0] cfg_des_v,
    input  logic                      ctrl_abort,
    output logic [IMG_H_BITWIDTH-1:0] core_arg_img_src_h,
    output logic [IMG_V_BITWIDTH-1:0] core_arg_img_src_v,
    output logic [IMG_H_BITWIDTH-1:0] core_arg_img_des_h,
    output logic [IMG_V_BITWIDTH-1:0] core_arg_img_des_v,
    output logic                      core_arg_mode,
    output logic [SF_BITWIDTH-1:0]    core_arg_hsf,
    output logic [SF_BITWIDTH-1:0]    core_arg_vsf,
    output logic                      core_start,
    input  logic                      m_axis_core_valid,
    input  logic                      m_axis_core_done,
    output logic                      ctrl_busy,
    output logic                      frame_done,
    output logic [1:0]                frame_status
);
    // cfg_valid/cfg_ready: a config is taken in the cycle both are high; cfg_ready is high only in IDLE,
    // and cfg_valid may be held or dropped freely while cfg_ready is low.
    localparam int DIM_W = DIV_W - SF_FRAC_BITWIDTH;
    localparam int CNT_W = $clog2(DIV_W);
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(DIV_W - 1);
    localparam logic [IMG_H_BITWIDTH:0]   H_MAX_L  = (IMG_H_BITWIDTH + 1)'(IMG_H_MAX);
    localparam logic [IMG_V_BITWIDTH:0]   V_MAX_L  = (IMG_V_BITWIDTH + 1)'(IMG_V_MAX);

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_BAD   = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DIV_H, S_DIV_V, S_START, S_RUN, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [IMG_H_BITWIDTH-1:0] src_h_q, src_h_d, des_h_q, des_h_d;
    logic [IMG_V_BITWIDTH-1:0] src_v_q, src_v_d, des_v_q, des_v_d;
    logic                      mode_q, mode_d;
    logic [SF_BITWIDTH-1:0]    hsf_q, hsf_d, vsf_q, vsf_d;
    logic [1:0]                status_q, status_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIM_W-1:0]          rem_q, rem_d;
    logic [DIV_W-1:0]          dvd_q, dvd_d;
    logic [DIV_W-2:0]          quo_q, quo_d;

    logic [DIM_W-1:0]          src_h_ext, src_v_ext, des_h_ext, des_v_ext, div_den;
    logic [DIM_W:0]            trial, rem_nxt;
    logic                      q_bit;
    logic [DIV_W-1:0]          quo_full;
    logic [SF_BITWIDTH-1:0]    sf_sat;
    logic                      div_unused;
    logic                      cfg_err, dim_zero, dim_big, up_any, down_any, mixed;
    logic [1:0]                run_status;

    assign src_h_ext = DIM_W'(src_h_q);
    assign src_v_ext = DIM_W'(src_v_q);
    assign des_h_ext = DIM_W'(des_h_q);
    assign des_v_ext = DIM_W'(des_v_q);

    // One restoring step per cycle; the remainder always stays below the divisor so it fits DIM_W bits.
    assign div_den    = (state_q == S_DIV_V) ? des_v_ext : des_h_ext;
    assign trial      = {rem_q, dvd_q[DIV_W-1]};
    assign q_bit      = (trial >= {1'b0, div_den});
    assign rem_nxt    = q_bit ? (trial - {1'b0, div_den}) : trial;
    assign div_unused = rem_nxt[DIM_W];
    assign quo_full   = {quo_q, q_bit};
    assign sf_sat     = (|quo_full[DIV_W-1:SF_BITWIDTH]) ? {SF_BITWIDTH{1'b1}} : quo_full[SF_BITWIDTH-1:0];

    assign dim_zero = (src_h_q == '0) || (src_v_q == '0) || (des_h_q == '0) || (des_v_q == '0);
    assign dim_big  = ({1'b0, src_h_q} > H_MAX_L) || ({1'b0, des_h_q} > H_MAX_L) ||
                      ({1'b0, src_v_q} > V_MAX_L) || ({1'b0, des_v_q} > V_MAX_L);
    assign up_any   = (des_h_q > src_h_q) || (des_v_q > src_v_q);
    assign down_any = (des_h_q < src_h_q) || (des_v_q < src_v_q);
    assign mixed    = up_any && down_any;
    assign cfg_err  = dim_zero || dim_big || mixed;

`ifdef SCALER_FRAME_CTRL_PIXCNT_CHECK_EN
    localparam int PIX_W = 24;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d, pix_tgt_q, pix_tgt_d, pix_cnt_now;

    // A strobe coincident with done is counted before the compare.
    assign pix_cnt_now = pix_cnt_q + (m_axis_core_valid ? PIX_W'(1) : PIX_W'(0));
    assign run_status  = (pix_cnt_now == pix_tgt_q) ? ST_OK : 2'd3;

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        pix_tgt_d = pix_tgt_q;
        if (state_q == S_DIV_V) begin
            pix_tgt_d = PIX_W'(des_h_q) * PIX_W'(des_v_q);
        end
        if (state_q == S_START) begin
            pix_cnt_d = '0;
        end else if (state_q == S_RUN && m_axis_core_valid) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            pix_cnt_q <= '0;
            pix_tgt_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            pix_tgt_q <= pix_tgt_d;
        end
    end
`else
    logic pix_unused;
    assign pix_unused = m_axis_core_valid;
    assign run_status = ST_OK;
`endif

    always_comb begin
        state_d    = state_q;
        src_h_d    = src_h_q;
        src_v_d    = src_v_q;
        des_h_d    = des_h_q;
        des_v_d    = des_v_q;
        mode_d     = mode_q;
        hsf_d      = hsf_q;
        vsf_d      = vsf_q;
        status_d   = status_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        quo_d      = quo_q;
        core_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    src_h_d  = cfg_src_h;
                    src_v_d  = cfg_src_v;
                    des_h_d  = cfg_des_h;
                    des_v_d  = cfg_des_v;
                    mode_d   = (cfg_des_h > cfg_src_h) || (cfg_des_v > cfg_src_v);
                    status_d = ST_OK;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (ctrl_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else if (cfg_err) begin
                    status_d = ST_BAD;
                    state_d  = S_DONE;
                end else begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    dvd_d   = {src_h_ext, {SF_FRAC_BITWIDTH{1'b0}}};
                    state_d = S_DIV_H;
                end
            end
            S_DIV_H, S_DIV_V: begin
                if (ctrl_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else begin
                    rem_d = rem_nxt[DIM_W-1:0];
                    quo_d = quo_full[DIV_W-2:0];
                    dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        rem_d = '0;
                        quo_d = '0;
                        if (state_q == S_DIV_H) begin
                            hsf_d   = sf_sat;
                            dvd_d   = {src_v_ext, {SF_FRAC_BITWIDTH{1'b0}}};
                            state_d = S_DIV_V;
                        end else begin
                            vsf_d   = sf_sat;
                            state_d = S_START;
                        end
                    end
                end
            end
            S_START: begin
                if (ctrl_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else begin
                    core_start = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (ctrl_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else if (m_axis_core_done) begin
                    status_d = run_status;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q  <= S_IDLE;
            src_h_q  <= '0;
            src_v_q  <= '0;
            des_h_q  <= '0;
            des_v_q  <= '0;
            mode_q   <= 1'b0;
            hsf_q    <= '0;
            vsf_q    <= '0;
            status_q <= ST_OK;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_h_q  <= src_h_d;
            src_v_q  <= src_v_d;
            des_h_q  <= des_h_d;
            des_v_q  <= des_v_d;
            mode_q   <= mode_d;
            hsf_q    <= hsf_d;
            vsf_q    <= vsf_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
        end
    end

    assign cfg_ready          = (state_q == S_IDLE);
    assign ctrl_busy          = (state_q != S_IDLE);
    assign frame_done         = (state_q == S_DONE);
    assign frame_status       = status_q;
    assign core_arg_img_src_h = src_h_q;
    assign core_arg_img_src_v = src_v_q;
    assign core_arg_img_des_h = des_h_q;
    assign core_arg_img_des_v = des_v_q;
    assign core_arg_mode      = mode_q;
    assign core_arg_hsf       = hsf_q;
    assign core_arg_vsf       = vsf_q;
endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Self-checking bench for scaler_frame_ctrl: directed and random frames against an arithmetic reference model.
module tb_scaler_frame_ctrl;
    localparam int DIV_W     = 32;
    localparam int START_CYC = 2 + 2 * DIV_W;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        cfg_valid, cfg_ready;
    logic [11:0] cfg_src_h, cfg_src_v, cfg_des_h, cfg_des_v;
    logic        ctrl_abort;
    logic [11:0] core_arg_img_src_h, core_arg_img_src_v, core_arg_img_des_h, core_arg_img_des_v;
    logic        core_arg_mode;
    logic [23:0] core_arg_hsf, core_arg_vsf;
    logic        core_start, m_axis_core_valid, m_axis_core_done;
    logic        ctrl_busy, frame_done;
    logic [1:0]  frame_status;

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  exp_q[$];

    scaler_frame_ctrl dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_src_h(cfg_src_h), .cfg_src_v(cfg_src_v), .cfg_des_h(cfg_des_h), .cfg_des_v(cfg_des_v),
        .ctrl_abort(ctrl_abort),
        .core_arg_img_src_h(core_arg_img_src_h), .core_arg_img_src_v(core_arg_img_src_v),
        .core_arg_img_des_h(core_arg_img_des_h), .core_arg_img_des_v(core_arg_img_des_v),
        .core_arg_mode(core_arg_mode), .core_arg_hsf(core_arg_hsf), .core_arg_vsf(core_arg_vsf),
        .core_start(core_start), .m_axis_core_valid(m_axis_core_valid), .m_axis_core_done(m_axis_core_done),
        .ctrl_busy(ctrl_busy), .frame_done(frame_done), .frame_status(frame_status)
    );

    // clock / reset
    always #5 core_clk = ~core_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: straight from the frame rules
    function automatic bit model_err(input int sh, input int sv, input int dh, input int dv);
        bit bad;
        bad = (sh == 0) || (sv == 0) || (dh == 0) || (dv == 0);
        bad = bad || (sh > 3840) || (dh > 3840) || (sv > 2160) || (dv > 2160);
        bad = bad || ((dh > sh) && (dv < sv)) || ((dh < sh) && (dv > sv));
        return bad;
    endfunction

    function automatic logic [23:0] model_sf(input int s, input int d);
        longint q;
        q = (longint'(s) * 1048576) / longint'(d);
        if (q > 64'hFF_FFFF) return 24'hFF_FFFF;
        return q[23:0];
    endfunction

    task automatic drive_idle();
        cfg_valid = 1'b0;
        ctrl_abort = 1'b0;
        m_axis_core_valid = 1'b0;
        m_axis_core_done = 1'b0;
        core_rst = 1'b0;
    endtask

    // One frame: handshake, then cycle n=1.. counted from the handshake cycle.
    task automatic run_frame(input int sh, input int sv, input int dh, input int dv, input int abort_cyc,
                             input bit abort_on_done, input int npix, input int rst_cyc);
        bit          err;
        int          done_cyc, ab, pix_first, e_start, e_done, obs_start, obs_done, wait_n;
        logic [1:0]  e_status;
        logic [23:0] e_hsf, e_vsf, a_hsf, a_vsf;
        logic        e_mode, a_mode;
        logic [11:0] a_sh, a_sv, a_dh, a_dv;
        bit          stop;

        err       = model_err(sh, sv, dh, dv);
        done_cyc  = START_CYC + 1 + int'($urandom_range(0, 4)) + ((npix > 0) ? npix - 1 : 0);
        pix_first = done_cyc - npix + 1;
        ab        = abort_on_done ? done_cyc : abort_cyc;
        e_mode    = (dh > sh) || (dv > sv);
        e_hsf     = err ? 24'h0 : model_sf(sh, dh);
        e_vsf     = err ? 24'h0 : model_sf(sv, dv);
        if (ab >= 1 && (err ? (ab == 1) : (ab <= done_cyc))) begin
            e_status = 2'd2;
            e_done   = ab + 1;
            e_start  = (ab <= START_CYC) ? -1 : START_CYC;
        end else if (err) begin
            e_status = 2'd1;
            e_done   = 2;
            e_start  = -1;
        end else begin
            e_start  = START_CYC;
            e_done   = done_cyc + 1;
`ifdef SCALER_FRAME_CTRL_PIXCNT_CHECK_EN
            e_status = (npix == dh * dv) ? 2'd0 : 2'd3;
`else
            e_status = 2'd0;
`endif
        end
        if (rst_cyc > 0) e_done = -1;

        wait_n = 0;
        @(negedge core_clk);
        while (!cfg_ready && wait_n < 100) begin
            @(negedge core_clk);
            wait_n++;
        end
        if (!cfg_ready) check_val("idle_wait", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_src_h = 12'(sh);
        cfg_src_v = 12'(sv);
        cfg_des_h = 12'(dh);
        cfg_des_v = 12'(dv);
        @(posedge core_clk);
        #1;
        cfg_valid = 1'b0;
        if (rst_cyc == 0) exp_q.push_back(e_status);

        obs_start = -1;
        obs_done  = -1;
        stop      = 1'b0;
        a_mode = 1'b0; a_hsf = '0; a_vsf = '0; a_sh = '0; a_sv = '0; a_dh = '0; a_dv = '0;
        for (int n = 1; n <= 400 && !stop; n++) begin
            ctrl_abort        = (n == ab);
            m_axis_core_done  = (n == done_cyc);
            m_axis_core_valid = (npix > 0) && (n >= pix_first) && (n <= done_cyc);
            core_rst          = (n == rst_cyc);
            @(negedge core_clk);
            if (core_start && obs_start < 0) begin
                obs_start = n;
                a_mode = core_arg_mode; a_hsf = core_arg_hsf; a_vsf = core_arg_vsf;
                a_sh = core_arg_img_src_h; a_sv = core_arg_img_src_v;
                a_dh = core_arg_img_des_h; a_dv = core_arg_img_des_v;
            end
            if (frame_done) begin
                obs_done = n;
                stop = 1'b1;
                if (exp_q.size() > 0) check_val("status", 64'(frame_status), 64'(exp_q.pop_front()));
            end
            if (rst_cyc > 0 && n == rst_cyc + 1) begin
                stop = 1'b1;
                check_val("rst_ready", 64'(cfg_ready), 64'd1);
                check_val("rst_busy", 64'(ctrl_busy), 64'd0);
                check_val("rst_start", 64'(core_start), 64'd0);
                check_val("rst_hsf", 64'(core_arg_hsf), 64'd0);
                check_val("rst_args", 64'({core_arg_img_src_h, core_arg_img_des_v, core_arg_mode}), 64'd0);
                check_val("rst_status", 64'(frame_status), 64'd0);
            end
            if (!stop) begin
                @(posedge core_clk);
                #1;
            end
        end
        drive_idle();
        exp_q.delete();

        check_val("start_cyc", 64'(obs_start), 64'(e_start));
        check_val("done_cyc", 64'(obs_done), 64'(e_done));
        if (e_start > 0 && obs_start > 0) begin
            check_val("mode", 64'(a_mode), 64'(e_mode));
            check_val("hsf", 64'(a_hsf), 64'(e_hsf));
            check_val("vsf", 64'(a_vsf), 64'(e_vsf));
            check_val("args", 64'({a_sh, a_sv, a_dh, a_dv}), 64'({12'(sh), 12'(sv), 12'(dh), 12'(dv)}));
        end
        if (rst_cyc == 0 && obs_done > 0) begin
            @(posedge core_clk);
            #1;
            @(negedge core_clk);
            check_val("status_hold", 64'(frame_status), 64'(e_status));
            check_val("done_single", 64'(frame_done), 64'd0);
            check_val("idle_ready", 64'(cfg_ready), 64'd1);
        end
    endtask

    // cfg_valid held high through an error frame: only taken again once IDLE is back
    task automatic hold_valid_test();
        bit exp_rdy[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit exp_fd[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge core_clk);
        cfg_valid = 1'b1;
        cfg_src_h = 12'd1920; cfg_src_v = 12'd1080; cfg_des_h = 12'd0; cfg_des_v = 12'd540;
        @(posedge core_clk);
        #1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge core_clk);
            check_val($sformatf("hold_ready_%0d", n), 64'(cfg_ready), 64'(exp_rdy[n-1]));
            check_val($sformatf("hold_done_%0d", n), 64'(frame_done), 64'(exp_fd[n-1]));
            check_val($sformatf("hold_start_%0d", n), 64'(core_start), 64'd0);
            if (exp_fd[n-1]) check_val("hold_status", 64'(frame_status), 64'd1);
            @(posedge core_clk);
            #1;
            if (n == 3) cfg_valid = 1'b0;
        end
        repeat (2) @(posedge core_clk);
        #1;
    endtask

    initial begin
        int sh, sv, dh, dv, kind, abc;
        drive_idle();
        cfg_src_h = '0; cfg_src_v = '0; cfg_des_h = '0; cfg_des_v = '0;
        core_rst = 1'b1;
        repeat (3) @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        @(negedge core_clk);
        check_val("reset_ready", 64'(cfg_ready), 64'd1);
        check_val("reset_busy", 64'(ctrl_busy), 64'd0);
        check_val("reset_outs", 64'({core_start, frame_done, frame_status, core_arg_mode}), 64'd0);
        check_val("reset_sf", 64'({core_arg_hsf, core_arg_vsf}), 64'd0);

        run_frame(1920, 1080, 960, 540, 0, 1'b0, 0, 0);
        run_frame(960, 540, 1920, 1080, 0, 1'b0, 0, 0);
        run_frame(1920, 1080, 1280, 720, 0, 1'b0, 2, 0);
        run_frame(3840, 2160, 1, 1, 0, 1'b0, 1, 0);
        run_frame(100, 100, 100, 100, 0, 1'b0, 0, 0);
        run_frame(3840, 2160, 3840, 2160, 0, 1'b0, 0, 0);
        run_frame(1920, 1080, 0, 540, 0, 1'b0, 0, 0);
        run_frame(1920, 1080, 3840, 540, 0, 1'b0, 0, 0);
        run_frame(4000, 10, 10, 10, 0, 1'b0, 0, 0);
        run_frame(1920, 1080, 960, 540, 40, 1'b0, 0, 0);
        run_frame(1920, 1080, 960, 540, 1, 1'b0, 0, 0);
        run_frame(1920, 1080, 960, 540, START_CYC, 1'b0, 0, 0);
        run_frame(1920, 1080, 960, 540, 0, 1'b1, 0, 0);
        run_frame(1920, 1080, 960, 540, 0, 1'b0, 0, START_CYC + 1);
        hold_valid_test();
        run_frame(4, 4, 2, 2, 0, 1'b0, 3, 0);
        run_frame(4, 4, 2, 2, 0, 1'b0, 4, 0);

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 3));
            sh = int'($urandom_range(1, 3840));
            sv = int'($urandom_range(1, 2160));
            abc = 0;
            case (kind)
                0: begin dh = int'($urandom_range(1, sh)); dv = int'($urandom_range(1, sv)); end
                1: begin dh = int'($urandom_range(sh, 3840)); dv = int'($urandom_range(sv, 2160)); end
                2: begin
                    sh = int'($urandom_range(0, 4095)); sv = int'($urandom_range(0, 4095));
                    dh = int'($urandom_range(0, 4095)); dv = int'($urandom_range(0, 4095));
                end
                default: begin
                    dh = int'($urandom_range(1, sh)); dv = int'($urandom_range(1, sv));
                    abc = int'($urandom_range(1, START_CYC + 4));
                end
            endcase
            run_frame(sh, sv, dh, dv, abc, 1'b0, int'($urandom_range(0, 5)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scaler_frame_ctrl.md
Name: scaler_frame_ctrl

Overview:
- Per-frame sequencer in front of scaler_core.
- Accepts one frame config (src/des dimensions), validates it, and derives the mode and the H/V scale factors with one shared iterative restoring divider.
- Drives stable core_arg_* values and pulses core_start, then waits for m_axis_core_done and reports completion or error status.

Parameters:
- IMG_H_MAX, 3840, max horizontal size.
- IMG_V_MAX, 2160, max vertical size.
- IMG_H_BITWIDTH, CLOG2(IMG_H_MAX), horizontal field width (12 by default).
- IMG_V_BITWIDTH, CLOG2(IMG_V_MAX), vertical field width (12 by default).
- SF_BITWIDTH, 24, scale factor width.
- SF_FRAC_BITWIDTH, 20, scale factor fraction bits.
- DIV_W, max(IMG_H_BITWIDTH,IMG_V_BITWIDTH)+SF_FRAC_BITWIDTH, divider iterations (32 by default).

Ports:
- core_clk  in  1  clock
- core_rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when both high
- cfg_src_h  in  IMG_H_BITWIDTH  source width
- cfg_src_v  in  IMG_V_BITWIDTH  source height
- cfg_des_h  in  IMG_H_BITWIDTH  destination width
- cfg_des_v  in  IMG_V_BITWIDTH  destination height
- ctrl_abort  in  1  abort current frame
- core_arg_img_src_h  out  IMG_H_BITWIDTH  latched source width
- core_arg_img_src_v  out  IMG_V_BITWIDTH  latched source height
- core_arg_img_des_h  out  IMG_H_BITWIDTH  latched destination width
- core_arg_img_des_v  out  IMG_V_BITWIDTH  latched destination height
- core_arg_mode  out  1  0=down, 1=up
- core_arg_hsf  out  SF_BITWIDTH  src_h/des_h, unsigned, SF_FRAC_BITWIDTH fraction bits
- core_arg_vsf  out  SF_BITWIDTH  src_v/des_v, same format
- core_start  out  1  one-cycle start pulse
- m_axis_core_valid  in  1  core output pixel strobe
- m_axis_core_done  in  1  core frame-done pulse
- ctrl_busy  out  1  high whenever not IDLE
- frame_done  out  1  one-cycle completion pulse
- frame_status  out  2  0=ok, 1=bad config, 2=aborted, 3=pixel count mismatch

Behaviour:
- Reset values: all outputs 0, except cfg_ready=1. State=IDLE.
- State flow: IDLE -> CHECK -> DIV_H -> DIV_V -> START -> RUN -> DONE -> IDLE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: latch all four dims into core_arg_img_*, go to CHECK.
  - cfg_ready=0 in every other state.
- CHECK (1 cycle):
  - Error if any dim is 0, src_h or des_h > IMG_H_MAX, or src_v or des_v > IMG_V_MAX.
  - Error if mixed direction: one axis up (des>src) and the other axis down (des<src).
  - On error: go to DONE with status 1; core_start never pulses.
  - Otherwise: mode=1 if any axis has des>src, else 0 (equal dims give mode 0). Go to DIV_H.
- DIV_H / DIV_V:
  - Each takes exactly DIV_W cycles, one quotient bit per cycle, MSB first.
  - Dividend = src<<SF_FRAC_BITWIDTH, zero-extended to DIV_W; divisor = des.
  - Quotient is floor.
  - If the quotient exceeds 2^SF_BITWIDTH-1, saturate to all ones; this is not an error.
  - Result registers to core_arg_hsf / core_arg_vsf at the end of the corresponding state.
- START: core_start=1 for one cycle, then RUN.
- Start latency: core_start is high exactly 2+2*DIV_W cycles after the handshake cycle (66 with defaults).
- Arg stability: core_arg_* are stable from START until the next accepted cfg; they may change only on a handshake.
- RUN: wait for m_axis_core_done, then DONE with status 0.
- DONE: frame_done=1 and frame_status valid for one cycle. frame_status holds until the next handshake. Then IDLE.
- ctrl_abort:
  - In CHECK, DIV_H, DIV_V, START or RUN, abort wins over every other event in that cycle, including m_axis_core_done in RUN. Go to DONE with status 2.
  - If abort coincides with START, core_start is suppressed.
  - Abort is ignored in IDLE and DONE.
- A m_axis_core_done pulse outside RUN is ignored.
- Reset asserted mid-frame returns everything to reset values on the next edge; no frame_done is issued.

Optional Feature:
- Macro: SCALER_FRAME_CTRL_PIXCNT_CHECK_EN.
- Defined:
  - A 24-bit counter clears at START and increments on m_axis_core_valid in RUN.
  - On m_axis_core_done, the count is compared with des_h*des_v, which is precomputed and registered during DIV_V. A mismatch gives status 3 instead of 0.
  - If m_axis_core_valid and m_axis_core_done arrive in the same cycle, that pixel is counted before the compare.
- Undefined: no counter or multiplier; status 3 never occurs.

Test Plan:
- 1920x1080 -> 960x540: mode=0, hsf=vsf=0x200000, core_start at cycle 66 after handshake; a done pulse gives frame_done with status 0.
- 960x540 -> 1920x1080: mode=1, hsf=vsf=0x080000. 1920x1080 -> 1280x720: hsf=vsf=0x180000.
- 3840x2160 -> 1x1: hsf=vsf=0xFFFFFF (saturated), status 0.
- des_h=0, or 1920x1080 -> 3840x540 (mixed direction): no core_start, frame_done in cycle 2 after handshake with status 1; cfg_valid held high during busy is not accepted until IDLE.
- Abort in DIV_V: no core_start, status 2. Abort in the same cycle as m_axis_core_done in RUN: status 2. Reset in RUN: outputs back to reset values, cfg_ready=1 on the next cycle.
- With the macro defined, 4x4 -> 2x2 with 3 valid strobes then done: status 3. With 4 strobes, the last one coincident with done: status 0.
